// File: rtl/di_test_endpoint.sv
// DI test endpoint: NUM_CH counter channels (stream + one-shot get registers) and a
// slow-ready register. Define DI_TEST_STATUS_EN to add the status register and overrun flag.
module di_test_ch #(
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 8,
  parameter int BURST_LEN   = 8
) (
  input  logic              if_clock,
  input  logic              resetb,
  input  logic              stream_rd,
  input  logic              get_rd,
  output logic              in_read,
  output logic              read_nxt,
  output logic              serv,
  output logic              get_serv,
  output logic [DATA_W-1:0] cnt
);
  localparam int PH_MAX = (WAIT_CYCLES > BURST_LEN) ? WAIT_CYCLES : BURST_LEN;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] WAIT_LAST  = PH_W'(WAIT_CYCLES - 1);
  localparam logic [PH_W-1:0] BURST_LAST = PH_W'(BURST_LEN - 1);

  logic [PH_W-1:0] ph;
  logic            pend;

  // A pending get and a direct read landing in the same cycle consume one word.
  always_comb begin
    get_serv = in_read && (pend || get_rd);
    serv     = get_serv || (in_read && stream_rd);
    read_nxt = in_read ? !(serv && ph == BURST_LAST) : (ph == WAIT_LAST);
  end

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      in_read <= 1'b0;
      ph      <= '0;
      pend    <= 1'b0;
      cnt     <= '0;
    end else begin
      in_read <= read_nxt;
      if (!in_read) begin
        ph <= (ph == WAIT_LAST) ? '0 : ph + 1'b1;
        if (get_rd) pend <= 1'b1;
      end else if (serv) begin
        ph   <= (ph == BURST_LAST) ? '0 : ph + 1'b1;
        cnt  <= cnt + 1'b1;
        pend <= 1'b0;
      end
    end
  end
endmodule

module di_test_endpoint #(
  parameter int          DATA_W       = 16,
  parameter int          NUM_CH       = 4,
  parameter logic [15:0] EP_ADDR      = 16'h0000,
  parameter logic [15:0] BASE_REG     = 16'h0000,
  parameter int          WAIT_CYCLES  = 8,
  parameter int          BURST_LEN    = 8,
  parameter int          SLOW_TIMEOUT = 31
) (
  input  logic              if_clock,
  input  logic              resetb,
  input  logic [15:0]       diEpAddr,
  input  logic [15:0]       diRegAddr,
  input  logic              diRead,
  input  logic              diWrite,
  input  logic [DATA_W-1:0] diRegDataIn,
  output logic [DATA_W-1:0] diRegDataOut,
  output logic              rd_ready,
  output logic              wr_ready
);
  localparam int NREG  = 2*NUM_CH + 2;
  localparam int TMO_W = $clog2(SLOW_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(SLOW_TIMEOUT);

  logic [16:0]                   off;
  logic                          in_map, sel_slow, sel_stat, unmapped, slow_acc, stat_rd, ovr;
  logic [NUM_CH-1:0]             sel_stream, sel_get, stream_rd, get_rd;
  logic [NUM_CH-1:0]             in_read, read_nxt, serv, get_serv;
  logic [NUM_CH-1:0][DATA_W-1:0] cnt;
  logic [TMO_W-1:0]              tmo, tmo_nxt;
  logic [DATA_W-1:0]             slow_val, status, dout_nxt;
  logic                          rd_nxt, wr_nxt;

  // 17-bit offset so addresses below BASE_REG fall out as unmapped.
  assign off    = {1'b0, diRegAddr} - {1'b0, BASE_REG};
  assign in_map = (diEpAddr == EP_ADDR) && !off[16] && (off[15:0] < 16'(NREG));

  always_comb begin
    sel_stream = '0;
    sel_get    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_stream[c] = in_map && (off[15:0] == 16'(2*c));
      sel_get[c]    = in_map && (off[15:0] == 16'(2*c + 1));
    end
  end

  assign sel_slow  = in_map && (off[15:0] == 16'(2*NUM_CH));
  assign unmapped  = !(|sel_stream || |sel_get || sel_slow || sel_stat);
  assign stream_rd = sel_stream & {NUM_CH{diRead && rd_ready}};
  assign get_rd    = sel_get & {NUM_CH{diRead}};
  assign stat_rd   = sel_stat && diRead;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    di_test_ch #(
      .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES), .BURST_LEN(BURST_LEN)
    ) u_ch (
      .if_clock (if_clock),
      .resetb   (resetb),
      .stream_rd(stream_rd[c]),
      .get_rd   (get_rd[c]),
      .in_read  (in_read[c]),
      .read_nxt (read_nxt[c]),
      .serv     (serv[c]),
      .get_serv (get_serv[c]),
      .cnt      (cnt[c])
    );
  end

`ifdef DI_TEST_STATUS_EN
  logic ovr_set;
  assign sel_stat = in_map && (off[15:0] == 16'(2*NUM_CH + 1));
  assign ovr_set  = |sel_stream && diRead && !rd_ready;
  always_ff @(posedge if_clock) begin
    if (!resetb) ovr <= 1'b0;
    else         ovr <= (ovr && !stat_rd) || ovr_set;
  end
`else
  assign sel_stat = 1'b0;
  assign ovr      = 1'b0;
`endif

  assign status = DATA_W'({ovr, in_read});

  // The slow timer restarts whenever the register is deselected or accessed.
  assign slow_acc = sel_slow && (diRead || diWrite) && (tmo == TMO_MAX);
  assign tmo_nxt  = (!sel_slow || slow_acc) ? '0 : (tmo == TMO_MAX) ? tmo : tmo + 1'b1;

  always_comb begin
    dout_nxt = diRegDataOut;
    for (int c = 0; c < NUM_CH; c++)
      if (serv[c]) dout_nxt = cnt[c];
    if (slow_acc && diRead) dout_nxt = slow_val;
    if (stat_rd)            dout_nxt = status;
    if (unmapped && diRead) dout_nxt = '0;
    rd_nxt = 1'b1;
    wr_nxt = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_stream[c]) rd_nxt = read_nxt[c];
      if (sel_get[c])    rd_nxt = get_serv[c];
    end
    if (sel_slow) begin
      rd_nxt = (tmo_nxt == TMO_MAX);
      wr_nxt = (tmo_nxt == TMO_MAX);
    end
  end

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      tmo          <= '0;
      slow_val     <= '0;
      diRegDataOut <= '0;
      rd_ready     <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      tmo          <= tmo_nxt;
      if (slow_acc && diWrite) slow_val <= diRegDataIn;
      diRegDataOut <= dout_nxt;
      rd_ready     <= rd_nxt;
      wr_ready     <= wr_nxt;
    end
  end
endmodule
